// File: rtl/cc_writeback_unit.sv
// Registered write-back stage: accepts one request at a time, sources data from the
// ALU or from memory (with timeout), and issues a one-cycle active-low load/clear strobe.
module cc_writeback_unit #(
  parameter int                        DATAWIDTH_BUS  = 32,
  parameter int                        DATAWIDTH_ADDR = 6,
  parameter int                        NUM_REGS       = 14,
  parameter logic [DATAWIDTH_ADDR-1:0] REG_BASE       = 6'd2,
  parameter int                        MEM_TIMEOUT    = 15
) (
  input  logic                      CC_WRITEBACK_UNIT_CLOCK_50,
  input  logic                      CC_WRITEBACK_UNIT_RESET_InHigh,
  input  logic                      CC_WRITEBACK_UNIT_Req_In,
  input  logic [1:0]                CC_WRITEBACK_UNIT_Op_In,
  input  logic                      CC_WRITEBACK_UNIT_Select_In,
  input  logic [DATAWIDTH_ADDR-2:0] CC_WRITEBACK_UNIT_ScratchpadSelection_InBus,
  input  logic [DATAWIDTH_ADDR-1:0] CC_WRITEBACK_UNIT_MIRSelection_InBus,
  input  logic [DATAWIDTH_BUS-1:0]  CC_WRITEBACK_UNIT_ALU_data_InBus,
  input  logic [DATAWIDTH_BUS-1:0]  CC_WRITEBACK_UNIT_Memory_data_InBus,
  input  logic                      CC_WRITEBACK_UNIT_MemValid_In,
  output logic                      CC_WRITEBACK_UNIT_MemRead_Out,
  output logic [DATAWIDTH_BUS-1:0]  CC_WRITEBACK_UNIT_data_OutBus,
  output logic [NUM_REGS-1:0]       CC_WRITEBACK_UNIT_Load_OutBus,
  output logic [NUM_REGS-1:0]       CC_WRITEBACK_UNIT_Clear_OutBus,
  output logic                      CC_WRITEBACK_UNIT_Busy_Out,
  output logic                      CC_WRITEBACK_UNIT_Error_Out
);

  localparam int         ADDR_EXT_W   = DATAWIDTH_ADDR + 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_WRITE, S_CLEAR} state_e;
  typedef enum logic [1:0] {OP_ALU = 2'b00, OP_MEM = 2'b01, OP_CLR = 2'b10, OP_RSV = 2'b11} op_e;

  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [NUM_REGS-1:0]        onehot_q, onehot_d;
  logic [DATAWIDTH_BUS-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0]        load_q, load_d;
  logic [NUM_REGS-1:0]        clear_q, clear_d;
  logic                       busy_q, busy_d;
  logic                       memrd_q, memrd_d;
  logic                       err_q, err_d;

  logic [DATAWIDTH_ADDR-1:0]  req_addr;
  logic [ADDR_EXT_W-1:0]      req_addr_ext;
  logic [NUM_REGS-1:0]        req_onehot;
  logic                       req_valid;
  op_e                        req_op;

  // Decode at one extra bit so REG_BASE+i can never wrap onto a low address.
  always_comb begin
    req_addr     = CC_WRITEBACK_UNIT_Select_In ? CC_WRITEBACK_UNIT_MIRSelection_InBus
                                               : {1'b0, CC_WRITEBACK_UNIT_ScratchpadSelection_InBus};
    req_addr_ext = {1'b0, req_addr};
    req_onehot   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      req_onehot[i] = (req_addr_ext == ADDR_EXT_W'(int'(REG_BASE) + i));
    end
  end

  assign req_valid = |req_onehot;
  assign req_op    = op_e'(CC_WRITEBACK_UNIT_Op_In);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    data_d   = data_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (CC_WRITEBACK_UNIT_Req_In) begin
          onehot_d = req_onehot;
          if (req_op == OP_RSV || !req_valid) begin
            err_d = 1'b1;
          end else begin
            unique case (req_op)
              OP_ALU: begin
                state_d = S_WRITE;
                data_d  = CC_WRITEBACK_UNIT_ALU_data_InBus;
              end
              OP_MEM: begin
                state_d = S_WAIT_MEM;
                cnt_d   = '0;
              end
              OP_CLR:  state_d = S_CLEAR;
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
      S_WAIT_MEM: begin
        cnt_d = cnt_q + 8'd1;
        // Valid data on the final count cycle takes priority over the timeout.
        if (CC_WRITEBACK_UNIT_MemValid_In) begin
          data_d  = CC_WRITEBACK_UNIT_Memory_data_InBus;
          state_d = S_WRITE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    load_d  = (state_d == S_WRITE) ? ~onehot_d : '1;
    clear_d = (state_d == S_CLEAR) ? ~onehot_d : '1;
    busy_d  = (state_d != S_IDLE);
    memrd_d = (state_d == S_WAIT_MEM);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CC_WRITEBACK_UNIT_CLOCK_50 or posedge CC_WRITEBACK_UNIT_RESET_InHigh) begin
    if (CC_WRITEBACK_UNIT_RESET_InHigh) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      data_q   <= '0;
      load_q   <= '1;
      clear_q  <= '1;
      busy_q   <= 1'b0;
      memrd_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      data_q   <= data_d;
      load_q   <= load_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
      memrd_q  <= memrd_d;
      err_q    <= err_d;
    end
  end

  assign CC_WRITEBACK_UNIT_MemRead_Out  = memrd_q;
  assign CC_WRITEBACK_UNIT_data_OutBus  = data_q;
  assign CC_WRITEBACK_UNIT_Load_OutBus  = load_q;
  assign CC_WRITEBACK_UNIT_Clear_OutBus = clear_q;
  assign CC_WRITEBACK_UNIT_Busy_Out     = busy_q;
  assign CC_WRITEBACK_UNIT_Error_Out    = err_q;

endmodule

// File: tb/tb_cc_writeback_unit.sv
// Bench for cc_writeback_unit: directed steps, with strobe/error events matched
// against a queue of expected events filled as each request is driven.
module tb_cc_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        sel = 1'b0;
  logic [4:0]  sp_addr = '0;
  logic [5:0]  mir_addr = '0;
  logic [31:0] alu_data = '0;
  logic [31:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_read;
  logic [31:0] data_out;
  logic [13:0] load_bus;
  logic [13:0] clear_bus;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef enum logic [1:0] {EV_LOAD, EV_CLEAR, EV_ERR} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [13:0] mask;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  cc_writeback_unit dut (
    .CC_WRITEBACK_UNIT_CLOCK_50                 (clk),
    .CC_WRITEBACK_UNIT_RESET_InHigh             (rst),
    .CC_WRITEBACK_UNIT_Req_In                   (req),
    .CC_WRITEBACK_UNIT_Op_In                    (op),
    .CC_WRITEBACK_UNIT_Select_In                (sel),
    .CC_WRITEBACK_UNIT_ScratchpadSelection_InBus(sp_addr),
    .CC_WRITEBACK_UNIT_MIRSelection_InBus       (mir_addr),
    .CC_WRITEBACK_UNIT_ALU_data_InBus           (alu_data),
    .CC_WRITEBACK_UNIT_Memory_data_InBus        (mem_data),
    .CC_WRITEBACK_UNIT_MemValid_In              (mem_valid),
    .CC_WRITEBACK_UNIT_MemRead_Out              (mem_read),
    .CC_WRITEBACK_UNIT_data_OutBus              (data_out),
    .CC_WRITEBACK_UNIT_Load_OutBus              (load_bus),
    .CC_WRITEBACK_UNIT_Clear_OutBus             (clear_bus),
    .CC_WRITEBACK_UNIT_Busy_Out                 (busy),
    .CC_WRITEBACK_UNIT_Error_Out                (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input int idx, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.mask = (k == EV_ERR) ? 14'd0 : 14'(1 << idx);
    e.data = (k == EV_LOAD) ? d : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic observe(input ev_e k, input logic [13:0] m, input logic [31:0] d);
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_unexpected: observed event=%s mask=%h expected no event", k.name(), m);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_kind", 32'(k), 32'(e.kind));
      check("sb_mask", 32'(m), 32'(e.mask));
      if (k == EV_LOAD) check("sb_data", d, e.data);
    end
  endtask

  // Outputs change only on rising edges; sample them on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (load_bus !== 14'h3FFF) observe(EV_LOAD, ~load_bus, data_out);
      if (clear_bus !== 14'h3FFF) observe(EV_CLEAR, ~clear_bus, 32'd0);
      if (err !== 1'b0) observe(EV_ERR, 14'd0, 32'd0);
    end
  end

  // Drives a request for one cycle; returns on the falling edge after it was sampled.
  task automatic issue(input logic [1:0] o, input logic s, input logic [4:0] spa,
                       input logic [5:0] mira, input logic [31:0] alu);
    @(negedge clk);
    req = 1'b1; op = o; sel = s; sp_addr = spa; mir_addr = mira; alu_data = alu;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    int rd_cnt;
    int err_cnt;

    repeat (2) @(negedge clk);
    check("rst_load", 32'(load_bus), 32'h3FFF);
    check("rst_clear", 32'(clear_bus), 32'h3FFF);
    check("rst_busy", 32'(busy), 0);
    check("rst_memrd", 32'(mem_read), 0);
    check("rst_err", 32'(err), 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;

    // ALU write, scratchpad addr 5 -> bit 3
    expect_ev(EV_LOAD, 3, 32'hDEADBEEF);
    issue(2'b00, 1'b0, 5'd5, 6'd0, 32'hDEADBEEF);
    alu_data = 32'h0;
    check("alu_load", 32'(load_bus), 32'h3FF7);
    check("alu_data", data_out, 32'hDEADBEEF);
    check("alu_busy", 32'(busy), 1);
    @(negedge clk);
    check("alu_load_idle", 32'(load_bus), 32'h3FFF);
    check("alu_busy_idle", 32'(busy), 0);

    // Req held for three cycles: first and third accepted, second ignored
    expect_ev(EV_LOAD, 8, 32'hA1A1A1A1);
    expect_ev(EV_LOAD, 8, 32'hA3A3A3A3);
    @(negedge clk);
    req = 1'b1; op = 2'b00; sel = 1'b1; mir_addr = 6'd10; alu_data = 32'hA1A1A1A1;
    @(negedge clk);
    alu_data = 32'hA2A2A2A2;
    check("b2b_busy1", 32'(busy), 1);
    @(negedge clk);
    alu_data = 32'hA3A3A3A3;
    check("b2b_busy_gap", 32'(busy), 0);
    @(negedge clk);
    req = 1'b0;
    check("b2b_data", data_out, 32'hA3A3A3A3);
    @(negedge clk);

    // Memory write, MIR addr 15 -> bit 13; valid during the request cycle is ignored
    expect_ev(EV_LOAD, 13, 32'h12345678);
    @(negedge clk);
    req = 1'b1; op = 2'b01; sel = 1'b1; mir_addr = 6'd15; mem_valid = 1'b1; mem_data = 32'hBADBAD00;
    @(negedge clk);
    req = 1'b0; mem_valid = 1'b0;
    check("mem_rd1", 32'(mem_read), 1);
    @(negedge clk);
    check("mem_rd2", 32'(mem_read), 1);
    @(negedge clk);
    check("mem_rd3", 32'(mem_read), 1);
    mem_valid = 1'b1; mem_data = 32'h12345678;
    @(negedge clk);
    mem_valid = 1'b0;
    check("mem_rd_done", 32'(mem_read), 0);
    check("mem_load", 32'(load_bus), 32'h1FFF);
    check("mem_data", data_out, 32'h12345678);
    @(negedge clk);

    // Memory timeout: 15 wait cycles then one error pulse
    expect_ev(EV_ERR, 0, 32'd0);
    issue(2'b01, 1'b0, 5'd2, 6'd0, 32'd0);
    rd_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_read) rd_cnt++;
      if (err) err_cnt++;
      @(negedge clk);
    end
    check("to_rd_cycles", 32'(rd_cnt), 15);
    check("to_err_pulses", 32'(err_cnt), 1);
    check("to_busy", 32'(busy), 0);

    // Valid on the final count cycle wins over the timeout; scratchpad 7 -> bit 5
    expect_ev(EV_LOAD, 5, 32'hCAFEF00D);
    issue(2'b01, 1'b0, 5'd7, 6'd0, 32'd0);
    for (int i = 1; i < 15; i++) @(negedge clk);
    check("last_rd", 32'(mem_read), 1);
    mem_valid = 1'b1; mem_data = 32'hCAFEF00D;
    @(negedge clk);
    mem_valid = 1'b0;
    check("last_load", 32'(load_bus), 32'h3FDF);
    check("last_err", 32'(err), 0);
    repeat (3) @(negedge clk);

    // Bad address 1, bad address 16, reserved op
    expect_ev(EV_ERR, 0, 32'd0);
    issue(2'b00, 1'b0, 5'd1, 6'd0, 32'hBAD0BAD0);
    check("bad1_err", 32'(err), 1);
    check("bad1_busy", 32'(busy), 0);
    @(negedge clk);
    check("bad1_err_end", 32'(err), 0);
    expect_ev(EV_ERR, 0, 32'd0);
    issue(2'b10, 1'b1, 5'd0, 6'd16, 32'd0);
    check("bad16_err", 32'(err), 1);
    @(negedge clk);
    expect_ev(EV_ERR, 0, 32'd0);
    issue(2'b11, 1'b0, 5'd4, 6'd0, 32'h0);
    check("rsv_err", 32'(err), 1);
    check("rsv_busy", 32'(busy), 0);
    @(negedge clk);

    // Clear addr 2 -> bit 0, data left unchanged
    expect_ev(EV_CLEAR, 0, 32'd0);
    issue(2'b10, 1'b0, 5'd2, 6'd0, 32'h0);
    check("clr_bus", 32'(clear_bus), 32'h3FFE);
    check("clr_data", data_out, 32'hCAFEF00D);
    @(negedge clk);
    check("clr_bus_idle", 32'(clear_bus), 32'h3FFF);

    // Reset mid-wait with Req held high; async clear, nothing follows
    @(negedge clk);
    req = 1'b1; op = 2'b01; sel = 1'b0; sp_addr = 5'd3;
    repeat (4) @(negedge clk);
    check("rstmid_rd_pre", 32'(mem_read), 1);
    #1 rst = 1'b1;
    mem_valid = 1'b1; mem_data = 32'h55555555;
    #1;
    check("rstmid_rd", 32'(mem_read), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_data", data_out, 0);
    check("rstmid_load", 32'(load_bus), 32'h3FFF);
    check("rstmid_err", 32'(err), 0);
    @(negedge clk);
    req = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_rd", 32'(mem_read), 0);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
